// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
// Register map: five byte-wide control registers at 0x00..0x04.
package spi_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam int         FRAME_BITS = 16;
  localparam logic [6:0] MAX_ADDR   = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle (sclk, copi, ncs) between a bus master and the peripheral.
// Pins are asynchronous to the peripheral's system clock.
interface spi_peripheral_if;

  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, copi, ncs);
  modport slave  (input  sclk, copi, ncs);

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer plus history flop for one asynchronous pin.
// Emits the synchronized level and single-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the synchronizer; keep last level for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register peripheral with five control registers.
// Frames are 16 bits MSB-first: W bit, 7-bit address, data byte.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_peripheral_if.slave         spi,
  output logic [7:0]              en_reg_out_7_0,
  output logic [7:0]              en_reg_out_15_8,
  output logic [7:0]              en_reg_pwm_7_0,
  output logic [7:0]              en_reg_pwm_15_8,
  output logic [7:0]              pwm_duty_cycle
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic unused_edges;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        frame_ok;

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .d     (spi.sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_copi (
    .clk   (clk),
    .rst   (rst),
    .d     (spi.copi),
    .level (copi_lvl),
    .rise  (copi_rise),
    .fall  (copi_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ncs (
    .clk   (clk),
    .rst   (rst),
    .d     (spi.ncs),
    .level (ncs_lvl),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // Mode 0 needs only the sclk rise, copi level and ncs edges.
  assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise,
                          copi_fall, ncs_lvl};

  assign frame_ok = (bit_cnt == 5'(FRAME_BITS))
                  & shreg[15]
                  & (shreg[14:8] <= MAX_ADDR);

  // Frame FSM: collect bits while selected, evaluate once on deselect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shreg <= {shreg[14:0], copi_lvl};
            if (bit_cnt != 5'd17) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (frame_ok) begin
            case (shreg[14:8])
              ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shreg[7:0];
              ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shreg[7:0];
              ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shreg[7:0];
              ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shreg[7:0];
              ADDR_PWM_DUTY:    pwm_duty_cycle  <= shreg[7:0];
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
